// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared display package: glyph codes and segment bit order
package disp_pkg;

    localparam logic [3:0] GLYPH_BLANK = 4'd10;
    localparam logic [3:0] GLYPH_DASH  = 4'd11;
    localparam logic [3:0] GLYPH_A     = 4'd12;
    localparam logic [3:0] GLYPH_P     = 4'd13;

    localparam int NUM_DIGITS = 6;

    // Segment vector is {dp,g,f,e,d,c,b,a}, active-high
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [7:0] seg_t;

    function automatic seg_t seg_from_gfedcba(input logic [6:0] gfedcba);
        return {1'b0, gfedcba};
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - glyph/alarm inputs and scanned display outputs
interface seg_scan_driver_if;
    import disp_pkg::*;

    logic [3:0] bch0;
    logic [3:0] bch1;
    logic [3:0] bch2;
    logic [3:0] bch3;
    logic [3:0] bch4;
    logic [3:0] bch5;
    logic       alarmAlert;
    seg_t       seg;
    logic [5:0] digit_en;
    logic       buzzer;

    modport master (
        output bch0, bch1, bch2, bch3, bch4, bch5, alarmAlert,
        input  seg, digit_en, buzzer
    );

    modport slave (
        input  bch0, bch1, bch2, bch3, bch4, bch5, alarmAlert,
        output seg, digit_en, buzzer
    );

endinterface

// File: rtl/seg_scan_driver_glyph_decode.sv
// rtl/seg_scan_driver_glyph_decode.sv - 4-bit glyph code to seven-segment pattern
module seg_glyph_decode
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output seg_t       seg
);

    always_comb begin
        seg = '0;
        case (code)
            4'd0:        seg = seg_from_gfedcba(7'h3F);
            4'd1:        seg = seg_from_gfedcba(7'h06);
            4'd2:        seg = seg_from_gfedcba(7'h5B);
            4'd3:        seg = seg_from_gfedcba(7'h4F);
            4'd4:        seg = seg_from_gfedcba(7'h66);
            4'd5:        seg = seg_from_gfedcba(7'h6D);
            4'd6:        seg = seg_from_gfedcba(7'h7D);
            4'd7:        seg = seg_from_gfedcba(7'h07);
            4'd8:        seg = seg_from_gfedcba(7'h7F);
            4'd9:        seg = seg_from_gfedcba(7'h6F);
            GLYPH_DASH:  seg = seg_from_gfedcba(7'h40);
            GLYPH_A:     seg = seg_from_gfedcba(7'h77);
            GLYPH_P:     seg = seg_from_gfedcba(7'h73);
            default:     seg = '0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - six-digit multiplexed display driver with frame snapshot and alarm blink
module seg_scan_driver
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1024,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_on;
    logic [3:0]    snap [NUM_DIGITS];

    logic pre_wrap;
    logic frame_end;
    logic show;
    seg_t dec_seg;

    assign pre_wrap  = (pre == PW'(SCAN_DIV - 1));
    assign frame_end = pre_wrap && (idx == 3'd5);
    assign show      = (pre >= PW'(GUARD)) && blink_on;

    seg_glyph_decode u_decode (
        .code (snap[idx]),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= GLYPH_BLANK;
            end
            bus.seg      <= '0;
            bus.digit_en <= '0;
            bus.buzzer   <= 1'b0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end

            // Whole-frame snapshot so a digit never changes partway through a scan
            if (frame_end) begin
                snap[0] <= bus.bch0;
                snap[1] <= bus.bch1;
                snap[2] <= bus.bch2;
                snap[3] <= bus.bch3;
                snap[4] <= bus.bch4;
                snap[5] <= bus.bch5;
            end

            if (!bus.alarmAlert) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_end) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            bus.digit_en <= show ? (6'b000001 << idx) : 6'b000000;
            bus.seg      <= show ? dec_seg : '0;
            bus.buzzer   <= bus.alarmAlert & blink_on;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;
    import disp_pkg::*;

    localparam int S     = 8;
    localparam int G     = 2;
    localparam int B     = 2;
    localparam int FRAME = 6 * S;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bch [6];
    logic       alarm;

    always #5 clk = ~clk;

    seg_scan_driver_if bus ();

    assign bus.bch0       = bch[0];
    assign bus.bch1       = bch[1];
    assign bus.bch2       = bch[2];
    assign bus.bch3       = bch[3];
    assign bus.bch4       = bch[4];
    assign bus.bch5       = bch[5];
    assign bus.alarmAlert = alarm;

    seg_scan_driver #(
        .SCAN_DIV     (S),
        .GUARD        (G),
        .BLINK_FRAMES (B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] glyph [16];
    logic [3:0] msnap [6];
    int         kcnt;
    int         mc, mp, mi;
    bit         mon;
    logic [7:0] exp_seg;
    logic [5:0] exp_den;
    logic       exp_buz;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Model: position derived from edge count since reset; blink from frame ends seen with alarm high
    initial begin
        glyph = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                  8'h7F, 8'h6F, 8'h00, 8'h40, 8'h77, 8'h73, 8'h00, 8'h00};
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc  = 0;
                kcnt = 0;
                for (int j = 0; j < 6; j++) msnap[j] = 4'd10;
                exp_seg = '0;
                exp_den = '0;
                exp_buz = 1'b0;
            end else begin
                mc  = cyc;
                mp  = mc % S;
                mi  = (mc / S) % 6;
                mon = ((kcnt / B) % 2) == 0;
                exp_den = (mp >= G && mon) ? 6'(1 << mi) : 6'd0;
                exp_seg = (exp_den != 0) ? glyph[msnap[mi]] : 8'h00;
                exp_buz = alarm && mon;
                if (mc % FRAME == FRAME - 1) begin
                    for (int j = 0; j < 6; j++) msnap[j] = bch[j];
                end
                if (!alarm) kcnt = 0;
                else if (mc % FRAME == FRAME - 1) kcnt++;
                cyc = mc + 1;
            end
            #1;
            chk("seg", bus.seg, exp_seg);
            chk("digit_en", bus.digit_en, exp_den);
            chk("buzzer", bus.buzzer, exp_buz);
            chk("onehot", int'($countones(bus.digit_en) <= 1), 1);
        end
    end

    task automatic wait_cyc(input int target);
        int b = 0;
        while (cyc != target && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (cyc != target) begin
            n_checks++;
            $display("FAIL wait_cyc: cycle %0d never reached, at %0d", target, cyc);
        end
    endtask

    task automatic lit(input string name, input int n, input logic [7:0] s,
                       input logic [5:0] d, input logic bz);
        wait_cyc(n);
        chk({name, "_seg"}, bus.seg, s);
        chk({name, "_den"}, bus.digit_en, d);
        chk({name, "_buz"}, bus.buzzer, bz);
    endtask

    initial begin
        reset = 1'b1;
        alarm = 1'b0;
        bch   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        @(negedge clk);
        @(negedge clk);
        chk("reset_seg", bus.seg, 0);
        chk("reset_den", bus.digit_en, 0);
        chk("reset_buz", bus.buzzer, 0);
        reset = 1'b0;

        lit("f1_guard", 1, 8'h00, 6'b000000, 1'b0);
        lit("f1_blank", 3, 8'h00, 6'b000001, 1'b0);
        lit("f2_guard", 50, 8'h00, 6'b000000, 1'b0);
        lit("f2_d0_first", 51, 8'h06, 6'b000001, 1'b0);
        lit("f2_d0_last", 56, 8'h06, 6'b000001, 1'b0);
        lit("f2_d1_guard", 57, 8'h00, 6'b000000, 1'b0);
        lit("f2_d5", 91, 8'h7D, 6'b100000, 1'b0);

        wait_cyc(100);
        bch[2] = 4'd7;
        lit("tear_old", 115, 8'h4F, 6'b000100, 1'b0);
        lit("tear_new", 163, 8'h07, 6'b000100, 1'b0);

        wait_cyc(170);
        bch[0] = 4'd12;
        bch[1] = 4'd10;
        bch[2] = 4'd13;
        lit("glyph_A", 195, 8'h77, 6'b000001, 1'b0);
        lit("glyph_blank", 203, 8'h00, 6'b000010, 1'b0);
        lit("glyph_P", 211, 8'h73, 6'b000100, 1'b0);

        wait_cyc(250);
        alarm = 1'b1;
        lit("alarm_on", 260, 8'h73, 6'b000100, 1'b1);
        lit("alarm_on_end", 336, 8'h7D, 6'b100000, 1'b1);
        lit("alarm_off", 337, 8'h00, 6'b000000, 1'b0);
        lit("alarm_off2", 385, 8'h00, 6'b000000, 1'b0);
        lit("alarm_on2_guard", 433, 8'h00, 6'b000000, 1'b1);
        lit("alarm_on2", 435, 8'h77, 6'b000001, 1'b1);
        lit("alarm_off3", 529, 8'h00, 6'b000000, 1'b0);

        wait_cyc(540);
        alarm = 1'b0;
        lit("drop_edge", 541, 8'h00, 6'b000000, 1'b0);
        lit("drop_resume", 542, 8'h00, 6'b000010, 1'b0);

        lit("pre_reset", 603, 8'h66, 6'b001000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_seg", bus.seg, 0);
        chk("async_den", bus.digit_en, 0);
        chk("async_buz", bus.buzzer, 0);
        @(negedge clk);
        reset = 1'b0;

        lit("post_rst_d0", 5, 8'h00, 6'b000001, 1'b0);
        lit("post_rst_d4", 35, 8'h00, 6'b010000, 1'b0);
        lit("post_rst_live", 51, 8'h77, 6'b000001, 1'b0);

        wait_cyc(60);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
